// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbitration slice.
//               Provides the arbiter state encoding, the default payload
//               width and a constant-evaluable ceil(log2) helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    WAIT_BUSY = 2'b10,
    WAIT_DONE = 2'b11
  } arb_state_t;

  localparam int DEF_DATA_W = 8;

  // ceil(log2(n)); callers guarantee n >= 2 so the result is at least 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick. Scans the request vector
//               starting one position after `last`, wrapping modulo N, and
//               returns the first set index.
// Ports       : req  [N-1:0]      request vector
//               last [IDX_W-1:0]  index of the previously serviced requester
//               win  [IDX_W-1:0]  winning index (0 when no request)
//               any               at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate back to the nearest so the nearest set
  // request after `last` is the one left in `win`.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % N);
      if (req[idx]) win = idx;
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin sequencer sharing one UART TX serializer among
//               N_REQ byte producers. One byte is accepted per grant, loaded
//               with a single-cycle strobe, and the next grant waits until
//               the serializer busy window has opened and closed (or the
//               busy flag failed to rise within BUSY_TO cycles).
// Ports       : CLK, RST (sync, active-low)
//               arb_en                  grant enable
//               req_valid / req_data    per-requester byte handshake
//               req_ack                 one-cycle acceptance pulse
//               TX_BUSY                 serializer busy flag
//               TX_P_DATA/TX_DATA_VALID byte and load strobe to serializer
//               grant_id                current or last granted requester
//               frame_done, tx_timeout  completion / busy-timeout pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BUSY_TO = 16,
  parameter int ID_W    = clog2(N_REQ)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    arb_en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  input  logic                    TX_BUSY,
  output logic [DATA_W-1:0]       TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic [ID_W-1:0]         grant_id,
  output logic                    frame_done,
  output logic                    tx_timeout
);

  localparam int TMR_W = clog2(BUSY_TO);

  arb_state_t         state_q,    state_d;
  logic [ID_W-1:0]    last_q,     last_d;
  logic [TMR_W-1:0]   timer_q,    timer_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
  logic [N_REQ-1:0]   ack_q,      ack_d;
  logic               load_q,     load_d;
  logic               done_q,     done_d;
  logic               tmo_q,      tmo_d;

  logic [ID_W-1:0]    pick_win;
  logic               pick_any;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_q),
    .win  (pick_win),
    .any  (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    timer_d    = timer_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    // Strobes and pulses are single-cycle: cleared unless set below.
    ack_d      = '0;
    load_d     = 1'b0;
    done_d     = 1'b0;
    tmo_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_en && pick_any) begin
          grant_id_d      = pick_win;
          tx_data_d       = req_data[pick_win*DATA_W +: DATA_W];
          ack_d[pick_win] = 1'b1;
          load_d          = 1'b1;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A busy flag arriving on the last allowed cycle still counts.
        if (TX_BUSY) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TMR_W'(BUSY_TO - 1)) begin
          tmo_d   = 1'b1;
          last_d  = grant_id_q;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!TX_BUSY) begin
          done_d  = 1'b1;
          last_d  = grant_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      timer_q    <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      ack_q      <= '0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      ack_q      <= ack_d;
      load_q     <= load_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign req_ack       = ack_q;
  assign TX_P_DATA     = tx_data_q;
  assign TX_DATA_VALID = load_q;
  assign grant_id      = grant_id_q;
  assign frame_done    = done_q;
  assign tx_timeout    = tmo_q;

endmodule
`default_nettype wire
